div32_seq: RTL and testbench

// - Iterative 32-bit RV32M divide unit: DIV, DIVU, REM, REMU. It is the inverse-direction companion to the carry-lookahead adder in the ALU datapath.
// - Restoring shift-subtract, one quotient bit per clock. It sits beside the ALU and stalls the core through BUSY until DONE.
// - Handshake is START/BUSY/DONE. RISC-V divide-by-zero and overflow results are produced exactly as the ISA requires.

---
 rtl/div32_seq_pkg.sv | 30 +++
 rtl/div32_seq_div_step.sv | 30 +++
 rtl/div32_seq.sv | 132 +++++++++++++
 tb/tb_div32_seq.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/div32_seq_pkg.sv
// div32_seq_pkg
//   Shared definitions for the iterative RV32M divide unit.
//   - XLEN / CNT_W : datapath width and iteration counter width
//   - op_e         : divide opcode encoding (funct3[1:0])
//   - state_e      : sequencer states, shared with decode and stall logic
//   - neg_if       : conditional two's complement negation, modulo 2^XLEN
package div32_seq_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } state_e;

    function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic en);
        return en ? (~v + XLEN'(1)) : v;
    endfunction

endpackage

// File: rtl/div32_seq_div_step.sv
// div_step
//   One restoring shift-subtract iteration (combinational).
//   - i_rem [32:0] : partial remainder before the step
//   - i_quo [31:0] : dividend/quotient shift register before the step
//   - i_div [31:0] : divisor magnitude
//   - o_rem [32:0] : partial remainder after the step
//   - o_quo [31:0] : quotient shift register after the step
module div_step
    import div32_seq_pkg::*;
(
    input  logic [XLEN:0]   i_rem,
    input  logic [XLEN-1:0] i_quo,
    input  logic [XLEN-1:0] i_div,
    output logic [XLEN:0]   o_rem,
    output logic [XLEN-1:0] o_quo
);

    // One spare bit above the 33-bit remainder so the trial sign is never lost.
    logic [XLEN+1:0] w_sh;
    logic [XLEN+1:0] w_trial;
    logic            w_ge;

    assign w_sh    = {i_rem, i_quo[XLEN-1]};
    assign w_trial = w_sh - {2'b00, i_div};
    assign w_ge    = ~w_trial[XLEN+1];

    assign o_rem = w_ge ? w_trial[XLEN:0] : w_sh[XLEN:0];
    assign o_quo = {i_quo[XLEN-2:0], w_ge};

endmodule

// File: rtl/div32_seq.sv
// div32_seq
//   Iterative RV32M DIV/DIVU/REM/REMU, one quotient bit per clock.
//   - i_clk, i_rst_n : clock, async active-low reset
//   - i_start        : request, accepted only when idle and not busy
//   - i_op           : 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   - i_a, i_b       : dividend / divisor, captured on acceptance
//   - o_busy         : high from the cycle after acceptance through the DONE cycle
//   - o_done         : one-cycle pulse, o_result valid
//   - o_result       : quotient or remainder, held until the next accepted start
//
//   state  | meaning
//   S_IDLE | waiting for start; also hosts the DONE-pulse cycle (busy still high)
//   S_CALC | 32 shift-subtract iterations
//   S_FIX  | sign correction and quotient/remainder select
//   S_DONE | raise o_done on the way back to idle
module div32_seq
    import div32_seq_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic [1:0]      i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);

    state_e          r_state;
    logic [XLEN:0]   r_rem;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_div;
    logic [CNT_W-1:0] r_cnt;
    logic            r_sel_rem;
    logic            r_neg_q;
    logic            r_neg_r;
    logic            r_busy;
    logic            r_done;
    logic [XLEN-1:0] r_result;

    logic            w_signed;
    logic [XLEN-1:0] w_a_abs;
    logic [XLEN-1:0] w_b_abs;
    logic            w_div0;
    logic            w_ovf;
    logic [XLEN-1:0] w_special;
    logic [XLEN:0]   w_rem_nxt;
    logic [XLEN-1:0] w_quo_nxt;

    assign w_signed = (i_op == OP_DIV) || (i_op == OP_REM);
    assign w_a_abs  = neg_if(i_a, w_signed & i_a[XLEN-1]);
    assign w_b_abs  = neg_if(i_b, w_signed & i_b[XLEN-1]);
    assign w_div0   = (i_b == '0);
    assign w_ovf    = w_signed && (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);

    // ISA-defined results that bypass the iteration entirely.
    assign w_special = w_div0 ? (i_op[1] ? i_a : 32'hFFFF_FFFF)
                              : (i_op[1] ? 32'h0000_0000 : 32'h8000_0000);

    div_step u_step (
        .i_rem (r_rem),
        .i_quo (r_quo),
        .i_div (r_div),
        .o_rem (w_rem_nxt),
        .o_quo (w_quo_nxt)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_rem     <= '0;
            r_quo     <= '0;
            r_div     <= '0;
            r_cnt     <= '0;
            r_sel_rem <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_result  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (r_busy) begin
                        // DONE-pulse cycle: finish the handshake, ignore start.
                        r_busy <= 1'b0;
                    end else if (i_start) begin
                        r_busy    <= 1'b1;
                        r_sel_rem <= i_op[1];
                        r_rem     <= '0;
                        r_quo     <= w_a_abs;
                        r_div     <= w_b_abs;
                        r_cnt     <= CNT_W'(XLEN);
                        r_neg_q   <= w_signed & (i_a[XLEN-1] ^ i_b[XLEN-1]);
                        r_neg_r   <= w_signed & i_a[XLEN-1];
                        if (w_div0 || w_ovf) begin
                            r_result <= w_special;
                            r_state  <= S_DONE;
                        end else begin
                            r_state  <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_result <= r_sel_rem ? neg_if(r_rem[XLEN-1:0], r_neg_r)
                                          : neg_if(r_quo, r_neg_q);
                    r_state  <= S_DONE;
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_result = r_result;

endmodule

// File: tb/tb_div32_seq.sv
module tb_div32_seq;
    import div32_seq_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        i_start;
    logic [1:0]  i_op;
    logic [31:0] i_a;
    logic [31:0] i_b;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_result;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb[$];

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    localparam int LAT_N = 34;
    localparam int LAT_S = 1;

    div32_seq dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_start  (i_start),
        .i_op     (i_op),
        .i_a      (i_a),
        .i_b      (i_b),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_result (o_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Independent RV32M reference.
    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic sgn;
        sgn = ~op[0];
        if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : 32'h8000_0000;
        case (op)
            2'b00: return $signed(a) / $signed(b);
            2'b01: return a / b;
            2'b10: return $signed(a) % $signed(b);
            default: return a % b;
        endcase
    endfunction

    // Scoreboard: every DONE pulse pops one expected result.
    always @(negedge clk) begin
        if (rst_n && o_done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done actual=1 expected=0");
            end else begin
                chk("result", o_result, sb.pop_front());
            end
        end
    end

    // Issue one op, scramble inputs after acceptance, measure latency.
    // inject_at >= 0 pulses a DIVU 1/1 start mid-flight; start_in_done drives start in the DONE cycle.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat, input int inject_at,
                          input bit start_in_done);
        int cyc;
        @(negedge clk);
        i_start = 1'b1; i_op = op; i_a = a; i_b = b;
        sb.push_back(exp);
        @(negedge clk);
        i_start = 1'b0; i_op = ~op; i_a = ~a; i_b = 32'h1;
        chk("busy_after_accept", {31'b0, o_busy}, 32'h1);
        cyc = 0;
        while (!o_done && cyc < 100) begin
            if (cyc == inject_at) begin
                i_start = 1'b1; i_op = OP_DIVU; i_a = 32'h1; i_b = 32'h1;
            end
            @(negedge clk);
            cyc++;
            i_start = 1'b0;
        end
        if (!o_done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=%0d expected=%0d", cyc, lat);
            void'(sb.pop_front());
        end else begin
            chk("latency", cyc, lat);
            chk("busy_in_done", {31'b0, o_busy}, 32'h1);
        end
        if (start_in_done) begin
            i_start = 1'b1; i_op = OP_DIVU; i_a = 32'd9; i_b = 32'd3;
        end
        @(negedge clk);
        i_start = 1'b0;
        chk("done_single_pulse", {31'b0, o_done}, 32'h0);
        chk("busy_cleared", {31'b0, o_busy}, 32'h0);
    endtask

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra, rb;

        rst_n = 1'b0; i_start = 1'b0; i_op = 2'b00; i_a = '0; i_b = '0;
        #1;
        chk("rst_busy", {31'b0, o_busy}, 32'h0);
        chk("rst_done", {31'b0, o_done}, 32'h0);
        chk("rst_result", o_result, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        vecs.push_back('{OP_DIVU, 32'd100,        32'd7,        32'd14,        LAT_N});
        vecs.push_back('{OP_REMU, 32'd100,        32'd7,        32'd2,         LAT_N});
        vecs.push_back('{OP_DIV,  32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFD, LAT_N});
        vecs.push_back('{OP_REM,  32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFF, LAT_N});
        vecs.push_back('{OP_DIVU, 32'h1234_5678,  32'd0,        32'hFFFF_FFFF, LAT_S});
        vecs.push_back('{OP_REM,  32'h1234_5678,  32'd0,        32'h1234_5678, LAT_S});
        vecs.push_back('{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, LAT_S});
        vecs.push_back('{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF, 32'h0,        LAT_S});
        vecs.push_back('{OP_DIV,  32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, LAT_N});
        vecs.push_back('{OP_REM,  32'd7,          32'hFFFF_FFFE, 32'd1,        LAT_N});
        vecs.push_back('{OP_DIV,  32'hFFFF_FF9C,  32'hFFFF_FFF9, 32'd14,       LAT_N});
        vecs.push_back('{OP_REM,  32'hFFFF_FF9C,  32'hFFFF_FFF9, 32'hFFFF_FFFE, LAT_N});
        vecs.push_back('{OP_DIVU, 32'd5,          32'd10,       32'd0,         LAT_N});
        vecs.push_back('{OP_REMU, 32'd5,          32'd10,       32'd5,         LAT_N});
        vecs.push_back('{OP_DIVU, 32'h8000_0000,  32'd1,        32'h8000_0000, LAT_N});
        vecs.push_back('{OP_DIVU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd1,        LAT_N});
        vecs.push_back('{OP_DIV,  32'hFFFF_FFF0,  32'd0,        32'hFFFF_FFFF, LAT_S});
        vecs.push_back('{OP_REMU, 32'hDEAD_BEEF,  32'd0,        32'hDEAD_BEEF, LAT_S});
        vecs.push_back('{OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,        LAT_N});
        vecs.push_back('{OP_REM,  32'h8000_0000,  32'd1,        32'h0,         LAT_N});

        for (int i = 0; i < vecs.size(); i++)
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, -1, (i == 3));

        for (int i = 0; i < 16; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = (i % 4 == 0) ? 32'($urandom_range(1, 255)) : $urandom;
            run_op(rop, ra, rb, ref_div(rop, ra, rb),
                   (rb == 0 || (!rop[0] && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF)) ? LAT_S : LAT_N,
                   -1, 1'b0);
        end

        // Start pulsed mid-operation must not disturb the op in flight.
        run_op(OP_DIVU, 32'd100, 32'd7, 32'd14, LAT_N, 10, 1'b0);

        // Reset mid-operation: everything clears at once and no DONE follows.
        @(negedge clk);
        i_start = 1'b1; i_op = OP_DIVU; i_a = 32'd100; i_b = 32'd7;
        @(negedge clk);
        i_start = 1'b0;
        repeat (15) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'b0, o_busy}, 32'h0);
        chk("abort_done", {31'b0, o_done}, 32'h0);
        chk("abort_result", o_result, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_op(OP_DIVU, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, LAT_N, -1, 1'b0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
